// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Four-digit BCD countdown timer. A preset is loaded, then the
//               count is decremented by one on every divided-clock tick while
//               running. The count stops at zero and expiry is flagged.
//               Digit layout matches the stopwatch: digit0..digit2 are mod-10,
//               digit3 is mod-TOP_MOD.
//
// Parameters  : TOP_MOD         modulus of digit3, legal range 2..10
//
// Ports       : clock           system clock, rising-edge active
//               reset           asynchronous, active-high reset
//               tick            one-cycle decrement enable from clock divider
//               load            capture preset into count and preset register
//               preset[15:0]    BCD preset {digit3, digit2, digit1, digit0}
//               start_stop      one-cycle pulse: run/pause toggle, expiry ack
//               count[15:0]     current BCD value, same packing as preset
//               running         high while in RUN
//               expired         high while in DONE
//               expired_pulse   one-cycle pulse after count reaches zero
//               preset_err      one-cycle pulse after a rejected load
//
// Options     : COUNTDOWN_AUTO_RELOAD_EN
//               When defined, reaching zero reloads the preset register value
//               and keeps running (DONE becomes unreachable). A zero preset
//               register falls back to the normal stop-at-zero behaviour.
//
// Revision    : 1.0  initial release
// ============================================================================
module countdown_timer #(
  parameter int TOP_MOD = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        start_stop,
  output logic [15:0] count,
  output logic        running,
  output logic        expired,
  output logic        expired_pulse,
  output logic        preset_err
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Largest legal value of the most significant digit.
  localparam logic [3:0] c_TOP_MAX = 4'(TOP_MOD - 1);
  localparam logic [3:0] c_NINE    = 4'd9;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_preset;
  logic        r_expired_pulse;
  logic        r_preset_err;

  // Next-state values
  state_t      w_state_nxt;
  logic [15:0] w_count_nxt;
  logic [15:0] w_preset_nxt;
  logic        w_expired_pulse_nxt;
  logic        w_preset_err_nxt;

  // --------------------------------------------------------------------------
  // Preset validation
  // --------------------------------------------------------------------------
  logic w_preset_valid;

  always_comb begin
    w_preset_valid = (preset[3:0]   <= c_NINE)    &&
                     (preset[7:4]   <= c_NINE)    &&
                     (preset[11:8]  <= c_NINE)    &&
                     (preset[15:12] <= c_TOP_MAX);
  end

  // --------------------------------------------------------------------------
  // Chained BCD subtract-one
  // Each digit borrows from the one above only when it and every digit below
  // it are zero. digit3 never wraps: the terminal-count path takes over before
  // the count could go below zero.
  // --------------------------------------------------------------------------
  logic [3:0] w_d0, w_d1, w_d2, w_d3;
  logic [3:0] w_dec0, w_dec1, w_dec2, w_dec3;
  logic       w_borrow0, w_borrow1, w_borrow2;
  logic [15:0] w_count_dec;

  always_comb begin
    w_d0 = r_count[3:0];
    w_d1 = r_count[7:4];
    w_d2 = r_count[11:8];
    w_d3 = r_count[15:12];

    w_borrow0 = (w_d0 == 4'd0);
    w_borrow1 = w_borrow0 && (w_d1 == 4'd0);
    w_borrow2 = w_borrow1 && (w_d2 == 4'd0);

    w_dec0 = w_borrow0 ? c_NINE : (w_d0 - 4'd1);

    if (!w_borrow0) begin
      w_dec1 = w_d1;
    end else if (w_d1 == 4'd0) begin
      w_dec1 = c_NINE;
    end else begin
      w_dec1 = w_d1 - 4'd1;
    end

    if (!w_borrow1) begin
      w_dec2 = w_d2;
    end else if (w_d2 == 4'd0) begin
      w_dec2 = c_NINE;
    end else begin
      w_dec2 = w_d2 - 4'd1;
    end

    w_dec3 = w_borrow2 ? (w_d3 - 4'd1) : w_d3;

    w_count_dec = {w_dec3, w_dec2, w_dec1, w_dec0};
  end

  // --------------------------------------------------------------------------
  // Terminal count detection
  // The zero case is treated as terminal too so that a RUN state holding zero
  // (not reachable in normal operation) can never underflow digit3.
  // --------------------------------------------------------------------------
  logic w_count_zero;
  logic w_terminal;

  always_comb begin
    w_count_zero = (r_count == 16'h0000);
    w_terminal   = (r_count == 16'h0001) || w_count_zero;
  end

  // Auto-reload is only honoured with a non-zero preset register; otherwise
  // expiry behaves exactly as in the default build.
  logic w_auto_reload;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_comb begin
    w_auto_reload = (r_preset != 16'h0000);
  end
`else
  always_comb begin
    w_auto_reload = 1'b0;
  end
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt         = r_state;
    w_count_nxt         = r_count;
    w_preset_nxt        = r_preset;
    w_expired_pulse_nxt = 1'b0;
    w_preset_err_nxt    = 1'b0;

    case (r_state)
      S_RUN: begin
        // load is ignored while running, without an error pulse.
        if (tick) begin
          if (w_terminal) begin
            w_expired_pulse_nxt = 1'b1;
            if (w_auto_reload) begin
              w_count_nxt = r_preset;
              w_state_nxt = start_stop ? S_PAUSE : S_RUN;
            end else begin
              // Reaching zero wins over a simultaneous pause request.
              w_count_nxt = 16'h0000;
              w_state_nxt = S_DONE;
            end
          end else begin
            w_count_nxt = w_count_dec;
            if (start_stop) begin
              w_state_nxt = S_PAUSE;
            end
          end
        end else if (start_stop) begin
          w_state_nxt = S_PAUSE;
        end
      end

      default: begin
        // IDLE, PAUSE and DONE all accept load; load beats start_stop.
        if (load) begin
          if (w_preset_valid) begin
            w_count_nxt  = preset;
            w_preset_nxt = preset;
            w_state_nxt  = S_IDLE;
          end else begin
            w_preset_err_nxt = 1'b1;
          end
        end else if (start_stop) begin
          case (r_state)
            S_IDLE:  w_state_nxt = w_count_zero ? S_IDLE : S_RUN;
            S_PAUSE: w_state_nxt = S_RUN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = r_state;
          endcase
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_count         <= 16'h0000;
      r_preset        <= 16'h0000;
      r_expired_pulse <= 1'b0;
      r_preset_err    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_count         <= w_count_nxt;
      r_preset        <= w_preset_nxt;
      r_expired_pulse <= w_expired_pulse_nxt;
      r_preset_err    <= w_preset_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    count         = r_count;
    running       = (r_state == S_RUN);
    expired       = (r_state == S_DONE);
    expired_pulse = r_expired_pulse;
    preset_err    = r_preset_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer (TOP_MOD = 6).
//               Table-driven vectors plus hand-written multi-cycle sequences.
//               Expectations follow COUNTDOWN_AUTO_RELOAD_EN when defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_countdown_timer;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        load;
  logic [15:0] preset;
  logic        start_stop;
  logic [15:0] count;
  logic        running;
  logic        expired;
  logic        expired_pulse;
  logic        preset_err;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.TOP_MOD(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .load          (load),
    .preset        (preset),
    .start_stop    (start_stop),
    .count         (count),
    .running       (running),
    .expired       (expired),
    .expired_pulse (expired_pulse),
    .preset_err    (preset_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic [15:0] pre;
    logic        ss;
    logic        tk;
    logic [15:0] cnt;
    logic        run;
    logic        exp;
    logic        pls;
    logic        err;
  } vec_t;

  vec_t vecs [13];

  // Decimal to packed BCD.
  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] c, input logic r,
                       input logic e, input logic p, input logic er);
    checks++;
    if (count !== c || running !== r || expired !== e ||
        expired_pulse !== p || preset_err !== er) begin
      errors++;
      $display("FAIL %s: got count=%h run=%b exp=%b pulse=%b err=%b, want count=%h run=%b exp=%b pulse=%b err=%b",
               name, count, running, expired, expired_pulse, preset_err, c, r, e, p, er);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample 1 ns after the
  // following rising edge, then return the inputs to idle.
  task automatic step(input logic ld, input logic [15:0] pre, input logic ss, input logic tk);
    @(negedge clock);
    load = ld; preset = pre; start_stop = ss; tick = tk;
    @(posedge clock);
    #1;
    load = 1'b0; start_stop = 1'b0; tick = 1'b0;
  endtask

  int pulses;
  logic saw_expired;
  logic [15:0] seq_exp [7];

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; preset = 16'h0000; start_stop = 1'b0;

    // ---------------- table of single-cycle vectors ----------------
    vecs[0]  = '{1'b1, 16'h0A00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}; // bad digit2
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}; // err is one cycle
    vecs[2]  = '{1'b1, 16'h6000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}; // digit3 = TOP_MOD
    vecs[3]  = '{1'b1, 16'h5999, 1'b0, 1'b0, 16'h5999, 1'b0, 1'b0, 1'b0, 1'b0}; // max legal
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5999, 1'b1, 1'b0, 1'b0, 1'b0}; // start
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5998, 1'b1, 1'b0, 1'b0, 1'b0}; // tick
    vecs[6]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h5998, 1'b1, 1'b0, 1'b0, 1'b0}; // load in RUN ignored
    vecs[7]  = '{1'b1, 16'hA000, 1'b0, 1'b1, 16'h5997, 1'b1, 1'b0, 1'b0, 1'b0}; // bad load in RUN, no err
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5997, 1'b0, 1'b0, 1'b0, 1'b0}; // pause
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5997, 1'b0, 1'b0, 1'b0, 1'b0}; // tick while paused
    vecs[10] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0}; // load beats start_stop
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0}; // start
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0, 1'b0}; // borrow chain

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].ld, vecs[i].pre, vecs[i].ss, vecs[i].tk);
      check($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].run, vecs[i].exp, vecs[i].pls, vecs[i].err);
    end

    // ---------------- 0099 down to 0001, then terminal ----------------
    for (int n = 98; n >= 1; n--) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check($sformatf("down_%0d", n), to_bcd(n), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("terminal_reload", 16'h0100, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("after_reload", 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pause_after_reload", 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    check("load_zero", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    check("terminal", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("pulse_one_cycle", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("tick_in_done", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("done_ack", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("start_at_zero", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- tick + start_stop in one RUN cycle ----------------
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("run_0005", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    check("tick_and_pause", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check($sformatf("paused_hold%0d", i), 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("resume", 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 3; n >= 1; n--) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check($sformatf("resume_down%0d", n), to_bcd(n), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("resume_reload", 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
`else
    check("resume_done", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    // ---------------- terminal tick + start_stop together ----------------
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    check("load_in_done_or_pause", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("terminal_with_pause", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    check("done_beats_pause", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
    step(1'b1, 16'h1F00, 1'b0, 1'b0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    check("bad_load_pause", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    check("bad_load_done", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    // ---------------- preset 0003, seven ticks ----------------
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    seq_exp = '{16'h0002, 16'h0001, 16'h0003, 16'h0002, 16'h0001, 16'h0003, 16'h0002};
`else
    seq_exp = '{16'h0002, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif
    step(1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    pulses = 0;
    saw_expired = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      if (expired_pulse === 1'b1) pulses++;
      if (expired === 1'b1) saw_expired = 1'b1;
      checks++;
      if (count !== seq_exp[i]) begin
        errors++;
        $display("FAIL seq3_%0d: got count=%h, want %h", i, count, seq_exp[i]);
      end
    end
    checks++;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if (pulses != 2 || saw_expired !== 1'b0) begin
      errors++;
      $display("FAIL seq3_flags: got pulses=%0d expired_seen=%b, want pulses=2 expired_seen=0", pulses, saw_expired);
    end
`else
    if (pulses != 1 || saw_expired !== 1'b1) begin
      errors++;
      $display("FAIL seq3_flags: got pulses=%0d expired_seen=%b, want pulses=1 expired_seen=1", pulses, saw_expired);
    end
`endif

    // ---------------- asynchronous reset mid-run ----------------
    step(1'b1, 16'h0342, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("run_0342", 16'h0342, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
